// File: rtl/test_runner_pkg.sv
// Shared types and width helpers for the test_runner sequencer and its timer.
package test_runner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        RECORD,
        DONE
    } state_e;

    // One extra bit so the field can hold NUM_TESTS itself as well as every index.
    function automatic int cur_test_width(input int num_tests);
        return $clog2(num_tests) + 1;
    endfunction

    function automatic int fail_count_width(input int num_tests);
        return $clog2(num_tests) + 1;
    endfunction

    function automatic int timer_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage : test_runner_pkg

// File: rtl/runner_timer.sv
// Loadable up or down counter that saturates at TERM_VAL and flags it.
module runner_timer #(
    parameter int               WIDTH    = 4,
    parameter bit               COUNT_UP = 1'b0,
    parameter logic [WIDTH-1:0] TERM_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             term_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign term_o = (count_q == TERM_VAL);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !term_o) begin
            count_d = COUNT_UP ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : runner_timer

// File: rtl/test_runner.sv
// Sweeps NUM_TESTS attached tests one at a time and aggregates their verdicts.
// Optional per-test RUN timeout is enabled by defining TEST_RUNNER_TIMEOUT_EN.
module test_runner
    import test_runner_pkg::*;
#(
    parameter int NUM_TESTS      = 4,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic [NUM_TESTS-1:0]                   test_finish,
    input  logic [NUM_TESTS-1:0]                   test_fail,
    output logic [NUM_TESTS-1:0]                   test_reset,
    output logic [cur_test_width(NUM_TESTS)-1:0]   cur_test,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic [fail_count_width(NUM_TESTS)-1:0] fail_count,
    output logic [NUM_TESTS-1:0]                   fail_mask,
    output logic [NUM_TESTS-1:0]                   timeout_mask
);

    localparam int CW = cur_test_width(NUM_TESTS);
    localparam int FW = fail_count_width(NUM_TESTS);
    localparam int HW = timer_width(RESET_CYCLES);

    if (NUM_TESTS < 1 || NUM_TESTS > 32 || RESET_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("test_runner: parameter out of range");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        cur_test_q, cur_test_d;
    logic [FW-1:0]        fail_count_q, fail_count_d;
    logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
    logic                 fail_seen_q, fail_seen_d;

    logic [NUM_TESTS-1:0] cur_onehot;
    logic                 finish_sel;
    logic                 fail_sel;
    logic                 hold_load;
    logic                 hold_term;

    // A one-hot select avoids indexing the test vectors with the wider cur_test field.
    assign cur_onehot = NUM_TESTS'(1) << cur_test_q;
    assign finish_sel = |(test_finish & cur_onehot);
    assign fail_sel   = |(test_fail & cur_onehot);

    runner_timer #(
        .WIDTH    (HW),
        .COUNT_UP (1'b0),
        .TERM_VAL ('0)
    ) u_hold_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (hold_load),
        .load_val_i (HW'(RESET_CYCLES - 1)),
        .en_i       (state_q == HOLD),
        .term_o     (hold_term)
    );

`ifdef TEST_RUNNER_TIMEOUT_EN
    localparam int RW = timer_width(TIMEOUT_CYCLES);

    logic                 run_load;
    logic                 run_term;
    logic                 timed_out_q, timed_out_d;
    logic [NUM_TESTS-1:0] timeout_mask_q, timeout_mask_d;

    runner_timer #(
        .WIDTH    (RW),
        .COUNT_UP (1'b1),
        .TERM_VAL (RW'(TIMEOUT_CYCLES - 1))
    ) u_run_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (run_load),
        .load_val_i ('0),
        .en_i       (state_q == RUN),
        .term_o     (run_term)
    );

    assign timeout_mask = timeout_mask_q;
`else
    assign timeout_mask = '0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cur_test_d   = cur_test_q;
        fail_count_d = fail_count_q;
        fail_mask_d  = fail_mask_q;
        fail_seen_d  = fail_seen_q;
        hold_load    = 1'b0;
`ifdef TEST_RUNNER_TIMEOUT_EN
        run_load       = 1'b0;
        timed_out_d    = timed_out_q;
        timeout_mask_d = timeout_mask_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = HOLD;
                    cur_test_d   = '0;
                    fail_count_d = '0;
                    fail_mask_d  = '0;
                    hold_load    = 1'b1;
`ifdef TEST_RUNNER_TIMEOUT_EN
                    timeout_mask_d = '0;
`endif
                end
            end

            HOLD: begin
                if (hold_term) begin
                    state_d = RUN;
`ifdef TEST_RUNNER_TIMEOUT_EN
                    run_load = 1'b1;
`endif
                end
            end

            RUN: begin
                // Finish takes priority over a timeout landing in the same cycle.
                if (finish_sel) begin
                    state_d     = RECORD;
                    fail_seen_d = fail_sel;
`ifdef TEST_RUNNER_TIMEOUT_EN
                    timed_out_d = 1'b0;
                end else if (run_term) begin
                    state_d     = RECORD;
                    fail_seen_d = 1'b1;
                    timed_out_d = 1'b1;
`endif
                end
            end

            RECORD: begin
                if (fail_seen_q) begin
                    fail_mask_d  = fail_mask_q | cur_onehot;
                    fail_count_d = fail_count_q + FW'(1);
                end
`ifdef TEST_RUNNER_TIMEOUT_EN
                if (timed_out_q) begin
                    timeout_mask_d = timeout_mask_q | cur_onehot;
                end
`endif
                if (cur_test_q == CW'(NUM_TESTS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d    = HOLD;
                    cur_test_d = cur_test_q + CW'(1);
                    hold_load  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_test_q   <= '0;
            fail_count_q <= '0;
            fail_mask_q  <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_test_q   <= cur_test_d;
            fail_count_q <= fail_count_d;
            fail_mask_q  <= fail_mask_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

`ifdef TEST_RUNNER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timed_out_q    <= 1'b0;
            timeout_mask_q <= '0;
        end else begin
            timed_out_q    <= timed_out_d;
            timeout_mask_q <= timeout_mask_d;
        end
    end
`endif

    // Only the test being run sees its reset released, and only while in RUN.
    always_comb begin
        test_reset = '1;
        if (state_q == RUN) begin
            test_reset = ~cur_onehot;
        end
    end

    assign cur_test   = cur_test_q;
    assign fail_count = fail_count_q;
    assign fail_mask  = fail_mask_q;
    assign busy       = (state_q == HOLD) || (state_q == RUN) || (state_q == RECORD);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (fail_count_q == '0);

endmodule : test_runner

// File: tb/tb_test_runner.sv
// Self-checking bench for test_runner: stub tests with programmable finish delay,
// fail flag, never-finish and finish-held-through-reset behaviour.
module tb_test_runner;

    localparam int N  = 4;
    localparam int RC = 4;
    localparam int TO = 16;
    localparam int W  = $clog2(N) + 1;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b1;
    logic         start   = 1'b0;
    logic [N-1:0] test_finish;
    logic [N-1:0] test_fail;
    logic [N-1:0] test_reset;
    logic [W-1:0] cur_test;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W-1:0] fail_count;
    logic [N-1:0] fail_mask;
    logic [N-1:0] timeout_mask;

    int delay_cfg [N];
    bit fail_cfg  [N];
    bit never_cfg [N];
    bit hold_cfg  [N];
    int stub_cnt  [N];

    int n_checks = 0;
    int n_fail   = 0;

    test_runner #(
        .NUM_TESTS      (N),
        .RESET_CYCLES   (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .test_finish  (test_finish),
        .test_fail    (test_fail),
        .test_reset   (test_reset),
        .cur_test     (cur_test),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_count   (fail_count),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask)
    );

    always #5 clock = ~clock;

    // Stub tests: count cycles out of reset, finish once the count reaches the delay.
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            stub_cnt[i] <= test_reset[i] ? 0 : stub_cnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            test_finish[i] = hold_cfg[i] ||
                             (!never_cfg[i] && !test_reset[i] && stub_cnt[i] >= delay_cfg[i]);
            test_fail[i]   = fail_cfg[i] && test_finish[i];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            delay_cfg[i] = 3;
            fail_cfg[i]  = 1'b0;
            never_cfg[i] = 1'b0;
            hold_cfg[i]  = 1'b0;
        end
    endtask

    // Reference model: per-test RUN length and verdict from the configured stub behaviour.
    task automatic expect_sweep(output int cyc, output logic [N-1:0] fm, output logic [N-1:0] tm,
                                output int fc);
        cyc = 0;
        fm  = '0;
        tm  = '0;
        fc  = 0;
        for (int i = 0; i < N; i++) begin
            int  n_run;
            bit  timed;
            n_run = hold_cfg[i] ? 1 : (never_cfg[i] ? 1 << 30 : delay_cfg[i] + 1);
            timed = 1'b0;
`ifdef TEST_RUNNER_TIMEOUT_EN
            if (n_run > TO) begin
                n_run = TO;
                timed = 1'b1;
            end
`endif
            cyc += RC + n_run + 1;
            if (timed || fail_cfg[i]) begin
                fm[i] = 1'b1;
                fc++;
            end
            tm[i] = timed;
        end
    endtask

    task automatic run_and_check(input string name, input int extra_start);
        int           exp_cyc;
        int           exp_fc;
        logic [N-1:0] exp_fm;
        logic [N-1:0] exp_tm;
        int           cyc;
        expect_sweep(exp_cyc, exp_fm, exp_tm, exp_fc);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check({name, ".busy_after_start"}, busy, 1'b1);
        check({name, ".cleared_mask"}, fail_mask, '0);
        check({name, ".cleared_count"}, fail_count, '0);
        cyc = 0;
        while (!done && cyc < exp_cyc + 50) begin
            @(negedge clock);
            cyc++;
            start = (cyc == extra_start);
        end
        start = 1'b0;
        check({name, ".done"}, done, 1'b1);
        check({name, ".cycles"}, cyc, exp_cyc);
        check({name, ".busy_low"}, busy, 1'b0);
        check({name, ".pass"}, pass, exp_fc == 0);
        check({name, ".fail_count"}, fail_count, exp_fc);
        check({name, ".fail_mask"}, fail_mask, exp_fm);
        check({name, ".timeout_mask"}, timeout_mask, exp_tm);
        check({name, ".all_reset"}, test_reset, {N{1'b1}});
    endtask

    initial begin
        int k;
        clear_cfg();

        #1 reset_n = 1'b0;
        #1;
        check("rst.test_reset", test_reset, {N{1'b1}});
        check("rst.cur_test", cur_test, 0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.pass", pass, 1'b0);
        check("rst.fail_count", fail_count, 0);
        check("rst.fail_mask", fail_mask, 0);
        check("rst.timeout_mask", timeout_mask, 0);
        @(negedge clock) reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle.no_start_busy", busy, 1'b0);
        check("idle.no_start_done", done, 1'b0);

        // All stubs pass after 3 cycles.
        run_and_check("all_pass", -1);

        // Stub 2 fails alongside finish.
        fail_cfg[2] = 1'b1;
        run_and_check("stub2_fail", -1);

        // Start in DONE re-runs with identical results.
        run_and_check("rerun_from_done", -1);

        // Start while busy is ignored.
        run_and_check("start_while_busy", 12);

        // Finish held high through HOLD is recorded at the first RUN cycle.
        clear_cfg();
        hold_cfg[3]  = 1'b1;
        delay_cfg[3] = 6;
        fail_cfg[3]  = 1'b1;
        run_and_check("finish_in_hold", -1);

        // Randomized sweeps.
        for (int r = 0; r < 6; r++) begin
            clear_cfg();
            for (int i = 0; i < N; i++) begin
                delay_cfg[i] = $urandom_range(0, 6);
                fail_cfg[i]  = $urandom_range(0, 1) == 1;
                hold_cfg[i]  = $urandom_range(0, 7) == 0;
            end
            run_and_check($sformatf("rand%0d", r), -1);
        end

`ifdef TEST_RUNNER_TIMEOUT_EN
        // Stub 1 never finishes; stub 2 finishes on the timeout cycle; stub 3 one cycle late.
        clear_cfg();
        never_cfg[1] = 1'b1;
        delay_cfg[2] = TO - 1;
        delay_cfg[3] = TO;
        run_and_check("timeout", -1);
`endif

        // Asynchronous reset in the middle of test 2's RUN.
        clear_cfg();
        fail_cfg[0] = 1'b1;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        k = 0;
        while (!(cur_test == W'(2) && test_reset[2] == 1'b0) && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("midrst.reached_run2", (cur_test == W'(2)) && !test_reset[2], 1'b1);
        check("midrst.pre_fail_count", fail_count, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.test_reset", test_reset, {N{1'b1}});
        check("midrst.cur_test", cur_test, 0);
        check("midrst.busy", busy, 1'b0);
        check("midrst.done", done, 1'b0);
        check("midrst.pass", pass, 1'b0);
        check("midrst.fail_count", fail_count, 0);
        check("midrst.fail_mask", fail_mask, 0);
        check("midrst.timeout_mask", timeout_mask, 0);
        @(negedge clock) reset_n = 1'b1;
        fail_cfg[0] = 1'b0;
        fail_cfg[1] = 1'b1;
        run_and_check("after_midrst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_test_runner
